// File: rtl/speed_meter.sv
// Encoder pulse-rate meter: synchronises and debounces enc_in, counts filtered rising
// edges over a fixed gate window and publishes the count with a one-cycle done strobe.
module speed_meter #(
    parameter int WIDTH_SPEED = 14,
    parameter int GATE_CYCLES = 1000,
    parameter int FILTER_LEN  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   enc_in,
    output logic [WIDTH_SPEED-1:0] speed,
    output logic                   done,
    output logic                   overflow
);
    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int RUN_W  = $clog2(FILTER_LEN + 1);
    localparam logic [GATE_W-1:0]      GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [RUN_W-1:0]       RUN_LAST  = RUN_W'(FILTER_LEN - 1);
    localparam logic [WIDTH_SPEED-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_REPORT
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_filt_level;
    logic [RUN_W-1:0]       r_filt_run;
    logic [GATE_W-1:0]      r_gate_cnt;
    logic [WIDTH_SPEED-1:0] r_pulse_cnt;
    logic                   r_sat;
    logic [WIDTH_SPEED-1:0] r_speed;
    logic                   r_overflow;

    logic                   w_rise;
    logic                   w_at_max;
    logic [WIDTH_SPEED-1:0] w_pulse_inc;
    logic                   w_sat_inc;

    // Synchroniser and level filter run in every state; only the counters are gated.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_filt_level <= 1'b0;
            r_filt_run   <= '0;
        end else begin
            r_sync1 <= enc_in;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt_level) begin
                r_filt_run <= '0;
            end else if (r_filt_run == RUN_LAST) begin
                r_filt_level <= ~r_filt_level;
                r_filt_run   <= '0;
            end else begin
                r_filt_run <= r_filt_run + 1'b1;
            end
        end
    end

    // The edge is counted on the same clock edge that flips the filter level to 1.
    assign w_rise      = ~r_filt_level & r_sync2 & (r_filt_run == RUN_LAST);
    assign w_at_max    = (r_pulse_cnt == CNT_MAX);
    assign w_pulse_inc = (w_rise && !w_at_max) ? r_pulse_cnt + 1'b1 : r_pulse_cnt;
    assign w_sat_inc   = r_sat | (w_rise & w_at_max);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (enable) w_state_next = S_MEASURE;
            S_MEASURE: begin
                if (!enable) begin
                    w_state_next = S_IDLE;
                end else if (r_gate_cnt == GATE_LAST) begin
                    w_state_next = S_REPORT;
                end
            end
            S_REPORT:  w_state_next = enable ? S_MEASURE : S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Results are loaded on entry to REPORT so speed/overflow are valid alongside done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gate_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_sat       <= 1'b0;
            r_speed     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_MEASURE: begin
                    if (!enable) begin
                        r_gate_cnt  <= '0;
                        r_pulse_cnt <= '0;
                        r_sat       <= 1'b0;
                    end else if (r_gate_cnt == GATE_LAST) begin
                        r_speed     <= w_pulse_inc;
                        r_overflow  <= w_sat_inc;
                        r_gate_cnt  <= '0;
                        r_pulse_cnt <= '0;
                        r_sat       <= 1'b0;
                    end else begin
                        r_gate_cnt  <= r_gate_cnt + 1'b1;
                        r_pulse_cnt <= w_pulse_inc;
                        r_sat       <= w_sat_inc;
                    end
                end
                S_REPORT: begin
                    r_gate_cnt <= '0;
                    if (enable) begin
                        r_pulse_cnt <= w_pulse_inc;
                        r_sat       <= w_sat_inc;
                    end else begin
                        r_pulse_cnt <= '0;
                        r_sat       <= 1'b0;
                    end
                end
                default: begin
                    r_gate_cnt  <= '0;
                    r_pulse_cnt <= '0;
                    r_sat       <= 1'b0;
                end
            endcase
        end
    end

    assign speed    = r_speed;
    assign overflow = r_overflow;
    assign done     = (r_state == S_REPORT);

endmodule

// File: tb/tb_speed_meter.sv
// Randomised scoreboard bench for speed_meter: a cycle-level reference model predicts
// each window report; a negedge monitor pops and compares whenever done is seen.
module tb_speed_meter;
    localparam int W    = 4;
    localparam int G    = 100;
    localparam int FL   = 2;
    localparam int MAXC = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         enc_in = 1'b0;
    logic [W-1:0] speed;
    logic         done;
    logic         overflow;

    speed_meter #(
        .WIDTH_SPEED(W),
        .GATE_CYCLES(G),
        .FILTER_LEN (FL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .enc_in  (enc_in),
        .speed   (speed),
        .done    (done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int spd;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   started = 1'b0;
    int   reports = 0;

    // Reference model: window edges are counted unbounded, then clamped when reported.
    bit m_s1, m_s2, m_level;
    int m_run, m_phase, m_win, m_held_spd;
    bit m_held_ovf;

    always @(posedge clk) begin
        bit s;
        bit rise;
        exp_t e;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
            m_phase = -1; m_win = 0; m_held_spd = 0; m_held_ovf = 0;
            exp_q.delete();
        end else begin
            s = m_s2;
            m_s2 = m_s1;
            m_s1 = enc_in;
            rise = 0;
            if (s != m_level) begin
                m_run++;
                if (m_run == FL) begin
                    m_level = s;
                    m_run = 0;
                    rise = s;
                end
            end else begin
                m_run = 0;
            end
            if (m_phase < 0) begin
                m_win = 0;
                if (enable) m_phase = 0;
            end else if (m_phase < G) begin
                if (rise) m_win++;
                if (!enable) begin
                    m_phase = -1;
                    m_win = 0;
                end else if (m_phase == G - 1) begin
                    e.spd = (m_win > MAXC) ? MAXC : m_win;
                    e.ovf = (m_win > MAXC);
                    exp_q.push_back(e);
                    m_held_spd = e.spd;
                    m_held_ovf = e.ovf;
                    m_phase = G;
                    m_win = 0;
                end else begin
                    m_phase++;
                end
            end else begin
                if (enable) begin
                    m_phase = 0;
                    m_win = rise ? 1 : 0;
                end else begin
                    m_phase = -1;
                    m_win = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (done === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done t=%0t got done=1 required done=0", $time);
                end else begin
                    e = exp_q.pop_front();
                    reports++;
                    if (int'(speed) != e.spd || overflow !== e.ovf) begin
                        miscompares++;
                        $display("FAIL report t=%0t got speed=%0d ovf=%0b required speed=%0d ovf=%0b",
                                 $time, speed, overflow, e.spd, e.ovf);
                    end else begin
                        $display("report t=%0t speed=%0d overflow=%0b", $time, speed, overflow);
                    end
                end
            end else begin
                vectors++;
                if (exp_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL missing_done t=%0t got done=%b required done=1", $time, done);
                    exp_q.delete();
                end else if (int'(speed) != m_held_spd || overflow !== m_held_ovf) begin
                    miscompares++;
                    $display("FAIL held t=%0t got speed=%0d ovf=%b required speed=%0d ovf=%0b",
                             $time, speed, overflow, m_held_spd, m_held_ovf);
                end
            end
        end
    end

    int hold = 0;

    task automatic drive(input int n, input int hmin, input int hmax,
                         input int lmin, input int lmax, input int drop_pct);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (hold <= 0) begin
                enc_in = ~enc_in;
                hold = enc_in ? int'($urandom_range(hmax, hmin)) : int'($urandom_range(lmax, lmin));
            end
            hold--;
            if (drop_pct != 0 && int'($urandom_range(99, 0)) < drop_pct) enable = ~enable;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        started = 1'b1;
        reset = 1'b0;
        enable = 1'b1;
        // steady 5/5 rate
        drive(6 * (G + 1), 5, 5, 5, 5, 0);
        // 1-cycle glitches rejected, then clean wider pulses
        drive(3 * (G + 1), 1, 1, 7, 7, 0);
        drive(3 * (G + 1), 3, 3, 5, 5, 0);
        // saturation followed by a slow window
        drive(3 * (G + 1), 2, 2, 2, 2, 0);
        drive(3 * (G + 1), 20, 20, 20, 20, 0);
        // abort mid-window, then resume
        drive(G / 2, 3, 4, 3, 4, 0);
        enable = 1'b0;
        drive(30, 3, 4, 3, 4, 0);
        enable = 1'b1;
        drive(2 * (G + 1) + 10, 3, 4, 3, 4, 0);
        // reset for two cycles mid-window with enable held
        drive(G / 3, 2, 5, 2, 5, 0);
        reset = 1'b1;
        drive(2, 2, 5, 2, 5, 0);
        reset = 1'b0;
        drive(3 * (G + 1), 2, 5, 2, 5, 0);
        // random mix including glitches and occasional enable toggles
        for (int k = 0; k < 8; k++) begin
            enable = 1'b1;
            drive(600, 1, 8, 1, 8, 1);
        end
        enable = 1'b0;
        drive(20, 1, 8, 1, 8, 0);
        vectors++;
        if (reports < 20) begin
            miscompares++;
            $display("FAIL report_count got %0d required at least 20", reports);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
